// File: rtl/alu_multiword_seq.sv
// rtl/alu_multiword_seq.sv - multi-precision ADC/SBB/shift sequencer driving one 16-bit combinational ALU
module alu_multiword_seq #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [WORDS*16-1:0] opa,
  input  logic [WORDS*16-1:0] opb,
  input  logic                cin_in,
  output logic                ready,
  output logic                done,
  output logic [WORDS*16-1:0] result,
  output logic [3:0]          flags,
  output logic [4:0]          alu_f,
  output logic [15:0]         alu_a,
  output logic [15:0]         alu_b,
  output logic                alu_cin,
  input  logic [15:0]         alu_result,
  input  logic [5:0]          alu_status
);

  localparam int W  = WORDS * 16;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  localparam logic [1:0] OP_ADC = 2'b00;
  localparam logic [1:0] OP_SBB = 2'b01;
  localparam logic [1:0] OP_SHL = 2'b10;
  localparam logic [1:0] OP_SHR = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [W-1:0]  work_q, work_d;
  logic [W-1:0]  result_q, result_d;
  logic [3:0]    flags_q, flags_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic          zacc_q, zacc_d;
  logic [15:0]   stored_word;
  logic          last;
  logic          unused_status;

  assign unused_status = ^{alu_status[4:3], alu_status[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      result_q <= '0;
      flags_q  <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      zacc_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      zacc_q   <= zacc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    work_d      = work_q;
    result_d    = result_q;
    flags_d     = flags_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    zacc_d      = zacc_q;
    alu_f       = 5'b00000;
    alu_a       = 16'h0000;
    alu_b       = 16'h0000;
    alu_cin     = 1'b0;
    stored_word = 16'h0000;
    last        = (op_q == OP_SHR) ? (idx_q == '0) : (idx_q == LAST_IDX);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = opa;
          b_d     = opb;
          carry_d = cin_in;
          idx_d   = (op == OP_SHR) ? LAST_IDX : '0;
          zacc_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        alu_a = a_q[{idx_q, 4'b0000} +: 16];
        case (op_q)
          OP_ADC: begin
            alu_f       = 5'b00101;
            alu_b       = b_q[{idx_q, 4'b0000} +: 16];
            alu_cin     = carry_q;
            stored_word = alu_result;
          end
          OP_SBB: begin
            alu_f       = 5'b00111;
            alu_b       = b_q[{idx_q, 4'b0000} +: 16];
            alu_cin     = carry_q;
            stored_word = alu_result;
          end
          OP_SHL: begin
            alu_f       = 5'b10000;
            stored_word = alu_result | {15'b0, carry_q};
          end
          default: begin
            alu_f       = 5'b10001;
            stored_word = alu_result | {carry_q, 15'b0};
          end
        endcase
        work_d[{idx_q, 4'b0000} +: 16] = stored_word;
        carry_d = alu_status[5];
        // Zero is judged on the stored word: the shift OR can make a zero ALU result nonzero.
        zacc_d  = zacc_q & (stored_word == 16'h0000);
        if (last) begin
          state_d  = S_DONE;
          result_d = work_d;
          flags_d  = {alu_status[5], zacc_d, work_d[W-1],
                      (op_q == OP_ADC || op_q == OP_SBB) ? alu_status[2] : 1'b0};
        end else begin
          idx_d = (op_q == OP_SHR) ? idx_q - 1'b1 : idx_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ready  = (state_q == S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_alu_multiword_seq.sv
// tb/tb_alu_multiword_seq.sv - scoreboard bench for alu_multiword_seq with a behavioural 16-bit ALU
module tb_alu_multiword_seq;
  localparam int WORDS = 4;
  localparam int W = WORDS * 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] opa = '0, opb = '0;
  logic         cin_in = 1'b0;
  logic         ready, done;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic [4:0]   alu_f;
  logic [15:0]  alu_a, alu_b, alu_result;
  logic         alu_cin;
  logic [5:0]   alu_status;

  int checks = 0;
  int fails = 0;
  logic [W+3:0] sb[$];

  alu_multiword_seq #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb), .cin_in(cin_in),
    .ready(ready), .done(done), .result(result), .flags(flags),
    .alu_f(alu_f), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_status(alu_status)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: {C,Z,N,V,P,A}
  logic        m_c, m_v;
  logic [15:0] m_r;
  always_comb begin
    m_c = 1'b0; m_v = 1'b0; m_r = 16'h0;
    case (alu_f)
      5'b00101: begin
        {m_c, m_r} = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0, alu_cin};
        m_v = (alu_a[15] == alu_b[15]) && (m_r[15] != alu_a[15]);
      end
      5'b00111: begin
        {m_c, m_r} = {1'b0, alu_a} - {1'b0, alu_b} - {16'h0, alu_cin};
        m_v = (alu_a[15] != alu_b[15]) && (m_r[15] != alu_a[15]);
      end
      5'b10000: begin m_r = {alu_a[14:0], 1'b0}; m_c = alu_a[15]; end
      5'b10001: begin m_r = {1'b0, alu_a[15:1]}; m_c = alu_a[0]; end
      default: ;
    endcase
  end
  assign alu_result = m_r;
  assign alu_status = {m_c, (m_r == 16'h0), m_r[15], m_v, ~^m_r, 1'b0};

  function automatic logic [W+3:0] ref_op(input logic [1:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic c);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         cf, vf;
    vf = 1'b0;
    case (o)
      2'b00: begin
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        r = full[W-1:0]; cf = full[W];
        vf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      2'b01: begin
        full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, c};
        r = full[W-1:0]; cf = full[W];
        vf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      2'b10: begin r = {a[W-2:0], c}; cf = a[W-1]; end
      default: begin r = {c, a[W-1:1]}; cf = a[0]; end
    endcase
    return {r, cf, (r == '0), r[W-1], vf};
  endfunction

  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: got done=1 with result %h, required no done", result);
      end else begin
        logic [W+3:0] exp;
        exp = sb.pop_front();
        if ({result, flags} !== exp) begin
          fails++;
          $display("FAIL result_flags: got %h/%b, required %h/%b", result, flags, exp[W+3:4], exp[3:0]);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 20) begin @(negedge clk); n++; end
    if (!ready) begin
      checks++; fails++;
      $display("FAIL ready_timeout: got ready=0, required 1");
    end
  endtask

  // Drive start for one cycle at a negedge; returns at the negedge of RUN cycle 1.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [W+3:0] exp);
    wait_ready();
    op = o; opa = a; opb = b; cin_in = c; start = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    opa = {$urandom, $urandom}; opb = {$urandom, $urandom}; op = 2'($urandom); cin_in = 1'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!done) begin fails++; $display("FAIL done_timeout: got done=0, required 1"); end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({ready, done, result, flags, alu_f, alu_a, alu_b, alu_cin} !== {1'b1, 1'b0, {W{1'b0}}, 4'h0, 5'h0, 16'h0, 16'h0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: got ready=%b done=%b result=%h flags=%b alu_f=%b, required 1 0 0 0 0",
               ready, done, result, flags, alu_f);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_adc_latency();
    launch(2'b00, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, {64'h0000_0000_0001_0000, 4'b0000});
    for (int cyc = 1; cyc <= 5; cyc++) begin
      checks++;
      if (ready !== 1'b0 || done !== (cyc == 5)) begin
        fails++;
        $display("FAIL adc_latency_c%0d: got ready=%b done=%b, required ready=0 done=%b", cyc, ready, done, cyc == 5);
      end
      @(negedge clk);
    end
    checks++;
    if (ready !== 1'b1) begin fails++; $display("FAIL ready_after_done: got %b, required 1", ready); end
  endtask

  task automatic test_adc_ripple();
    launch(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, {64'h0, 4'b1100});
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (alu_f !== 5'b00101 || alu_cin !== (w != 0)) begin
        fails++;
        $display("FAIL adc_cin_w%0d: got f=%b cin=%b, required f=00101 cin=%b", w, alu_f, alu_cin, w != 0);
      end
      @(negedge clk);
    end
    wait_done();
  endtask

  task automatic test_sbb();
    launch(2'b01, 64'h8000_0000_0000_0000, 64'h1, 1'b0, {64'h7FFF_FFFF_FFFF_FFFF, 4'b0001});
    wait_done();
  endtask

  task automatic test_shl();
    launch(2'b10, 64'h8000_0000_0000_8000, 64'hDEAD_BEEF_0000_1111, 1'b1, {64'h0000_0000_0001_0001, 4'b1000});
    wait_done();
  endtask

  task automatic test_shr();
    logic [15:0] ord[4];
    logic [W-1:0] a;
    launch(2'b11, 64'h0001_0000_0000_0001, 64'h0, 1'b0, {64'h0000_8000_0000_0000, 4'b1000});
    wait_done();
    a = 64'h4444_3333_2222_1111;
    ord[0] = 16'h4444; ord[1] = 16'h3333; ord[2] = 16'h2222; ord[3] = 16'h1111;
    launch(2'b11, a, 64'h0, 1'b1, ref_op(2'b11, a, 64'h0, 1'b1));
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (alu_f !== 5'b10001 || alu_a !== ord[k] || alu_b !== 16'h0) begin
        fails++;
        $display("FAIL shr_order_%0d: got f=%b a=%h b=%h, required f=10001 a=%h b=0000", k, alu_f, alu_a, alu_b, ord[k]);
      end
      @(negedge clk);
    end
    wait_done();
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      logic [1:0] o; logic [W-1:0] a, b; logic c;
      o = 2'(n % 4); c = 1'($urandom);
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      if (n % 6 == 5) b = ~a;
      if (n % 8 == 7) a = '0;
      launch(o, a, b, c, ref_op(o, a, b, c));
      wait_done();
    end
  endtask

  task automatic test_back_to_back();
    int t0, cyc;
    wait_ready();
    t0 = $time;
    for (int n = 0; n < 3; n++) begin
      logic [W-1:0] a, b; logic c;
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = 1'($urandom);
      launch(2'(n), a, b, c, ref_op(2'(n), a, b, c));
      while (!done && ($time - t0) < 400) @(negedge clk);
      @(negedge clk);
    end
    cyc = ($time - t0) / 10;
    checks++;
    if (cyc != 18 || ready !== 1'b1) begin
      fails++;
      $display("FAIL back_to_back: got %0d cycles ready=%b, required 18 cycles ready=1", cyc, ready);
    end
  endtask

  task automatic test_start_during_run();
    launch(2'b00, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b1,
           {64'h2345_6789_ABCD_F002, 4'b0000});
    op = 2'b01; opa = 64'hFFFF_0000_FFFF_0000; opb = 64'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin fails++; $display("FAIL ignored_start: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_reset_abort();
    launch(2'b00, 64'h5, 64'h7, 1'b0, {64'hC, 4'b0000});
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({ready, done, result, flags, alu_f} !== {1'b1, 1'b0, {W{1'b0}}, 4'h0, 5'h0}) begin
      fails++;
      $display("FAIL reset_abort: got ready=%b done=%b result=%h flags=%b alu_f=%b, required 1 0 0 0 0",
               ready, done, result, flags, alu_f);
    end
    repeat (10) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_adc_latency();
    test_adc_ripple();
    test_sbb();
    test_shl();
    test_shr();
    test_random();
    test_back_to_back();
    test_start_during_run();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
